// File: rtl/fpu_norm_round_pkg.sv
// fpu_norm_round_pkg: shared widths, rounding-mode encoding and special result constants for the normalize/round stage
package fpu_norm_round_pkg;
  localparam int C_EXP = 8;
  localparam int C_MANT = 23;
  localparam int C_EXP_PRENORM = C_EXP + 2;
  localparam int C_MANT_PRENORM = 2 * (C_MANT + 1);
  localparam logic [30:0] C_MAX_FINITE = 31'h7F7FFFFF;
  localparam logic [30:0] C_INF = 31'h7F800000;
  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;
  typedef struct packed {
    logic sign;
    logic [C_EXP_PRENORM-1:0] exp;
    logic [C_MANT_PRENORM-1:0] mant;
    logic sticky;
    logic tiny;
    logic zero;
    rm_e rm;
  } s1_t;
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero counter from the MSB
//   in_i   [W-1:0]  operand
//   cnt_o  [CW-1:0] number of zeros above the leading one (W when in_i is zero)
//   zero_o          in_i is all zeros
module fpu_lzc #(
  parameter int W = 48,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) if (in_i[i]) cnt_o = CW'(W - 1 - i);
  end
  assign zero_o = ~|in_i;
endmodule

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: two-stage normalize/round/pack of a prenormalized product into binary32 with OF/UF/NX
//   Clk_CI, Rst_RI (async, active-high)
//   In_Valid_SI/In_Ready_SO, Sign_prenorm_DI, Exp_prenorm_DI[9:0] (signed), Mant_prenorm_DI[47:0], Rm_SI[1:0]
//   Out_Valid_SO/Out_Ready_SI, Result_DO[31:0], OF_SO, UF_SO, NX_SO
//   FPU_NORM_FLUSH_DENORM_EN: flush tiny results to signed zero instead of gradual underflow
module fpu_norm_round
  import fpu_norm_round_pkg::*;
(
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        In_Valid_SI,
  output logic                        In_Ready_SO,
  input  logic                        Sign_prenorm_DI,
  input  logic [C_EXP_PRENORM-1:0]    Exp_prenorm_DI,
  input  logic [C_MANT_PRENORM-1:0]   Mant_prenorm_DI,
  input  logic [1:0]                  Rm_SI,
  output logic                        Out_Valid_SO,
  input  logic                        Out_Ready_SI,
  output logic [31:0]                 Result_DO,
  output logic                        OF_SO,
  output logic                        UF_SO,
  output logic                        NX_SO
);
  logic v1_q, v1_d, v2_q, v2_d, en1, en2;
  s1_t s1_n, s1_q, s1_d;
  logic [31:0] res_n, res_q, res_d;
  logic [2:0] flg_n, flg_q, flg_d;
  logic [5:0] lzc;
  logic mzero;
  logic [C_MANT_PRENORM-1:0] m_sh;
  logic signed [10:0] e_n;
  logic tiny;

  assign en2 = !v2_q || Out_Ready_SI;
  assign en1 = !v1_q || en2;
  assign In_Ready_SO = en1;

  fpu_lzc #(.W(C_MANT_PRENORM)) u_lzc (.in_i(Mant_prenorm_DI), .cnt_o(lzc), .zero_o(mzero));

  assign m_sh = Mant_prenorm_DI << lzc;
  assign e_n = $signed({Exp_prenorm_DI[C_EXP_PRENORM-1], Exp_prenorm_DI}) + 11'sd1 - $signed({5'd0, lzc});
  assign tiny = e_n <= 11'sd0;

`ifndef FPU_NORM_FLUSH_DENORM_EN
  logic [10:0] neg;
  logic [5:0] sh;
  logic [2*C_MANT_PRENORM-1:0] wide;
  assign neg = 11'(11'sd1 - e_n);
  assign sh = tiny ? (neg > 11'd48 ? 6'd48 : neg[5:0]) : 6'd0;
  // lower half collects everything shifted out for the sticky bit
  assign wide = {m_sh, {C_MANT_PRENORM{1'b0}}} >> sh;
`endif

  always_comb begin
    s1_n.sign = Sign_prenorm_DI;
    s1_n.rm = rm_e'(Rm_SI);
    s1_n.zero = mzero;
    s1_n.tiny = tiny;
    s1_n.exp = tiny ? '0 : e_n[C_EXP_PRENORM-1:0];
`ifdef FPU_NORM_FLUSH_DENORM_EN
    s1_n.mant = m_sh;
    s1_n.sticky = 1'b0;
`else
    s1_n.mant = wide[2*C_MANT_PRENORM-1:C_MANT_PRENORM];
    s1_n.sticky = |wide[C_MANT_PRENORM-1:0];
`endif
  end

  logic g, st, nx, inc, ovf, to_inf, s;
  logic [24:0] sum;
  logic [10:0] e_r;
  assign s = s1_q.sign;
  assign g = s1_q.mant[23];
  assign st = |s1_q.mant[22:0] || s1_q.sticky;
  assign nx = g || st;
  assign inc = s1_q.rm == RM_RNE ? g && (st || s1_q.mant[24]) :
               s1_q.rm == RM_RDN ? s && nx :
               s1_q.rm == RM_RUP ? !s && nx : 1'b0;
  assign sum = {1'b0, s1_q.mant[47:24]} + {24'd0, inc};
  // a subnormal carrying into the hidden bit becomes the smallest normal
  assign e_r = {1'b0, s1_q.exp} + {10'd0, s1_q.tiny ? sum[23] : sum[24]};
  assign ovf = e_r >= 11'd255;
  assign to_inf = s1_q.rm == RM_RNE || (s1_q.rm == RM_RDN && s) || (s1_q.rm == RM_RUP && !s);

  always_comb begin
    res_n = s1_q.zero ? {s, 31'd0} :
            ovf ? {s, to_inf ? C_INF : C_MAX_FINITE} :
`ifdef FPU_NORM_FLUSH_DENORM_EN
            s1_q.tiny ? {s, 31'd0} :
`endif
            {s, e_r[C_EXP-1:0], sum[C_MANT-1:0]};
`ifdef FPU_NORM_FLUSH_DENORM_EN
    flg_n = s1_q.zero ? 3'b000 : {ovf, s1_q.tiny, ovf || nx || s1_q.tiny};
`else
    flg_n = s1_q.zero ? 3'b000 : {ovf, s1_q.tiny && nx, ovf || nx};
`endif
  end

  assign v1_d = en1 ? In_Valid_SI : v1_q;
  assign s1_d = en1 && In_Valid_SI ? s1_n : s1_q;
  assign v2_d = en2 ? v1_q : v2_q;
  assign res_d = en2 && v1_q ? res_n : res_q;
  assign flg_d = en2 && v1_q ? flg_n : flg_q;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign Out_Valid_SO = v2_q;
  assign Result_DO = res_q;
  assign {OF_SO, UF_SO, NX_SO} = flg_q;
endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: directed and randomized checks of fpu_norm_round against a value-level rounding model
module tb_fpu_norm_round;
  logic Clk_CI = 1'b0, Rst_RI = 1'b1;
  logic In_Valid_SI = 1'b0, In_Ready_SO, Sign_prenorm_DI = 1'b0;
  logic [9:0] Exp_prenorm_DI = '0;
  logic [47:0] Mant_prenorm_DI = '0;
  logic [1:0] Rm_SI = '0;
  logic Out_Valid_SO, Out_Ready_SI = 1'b1;
  logic [31:0] Result_DO;
  logic OF_SO, UF_SO, NX_SO;

  fpu_norm_round dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .In_Valid_SI(In_Valid_SI), .In_Ready_SO(In_Ready_SO),
    .Sign_prenorm_DI(Sign_prenorm_DI), .Exp_prenorm_DI(Exp_prenorm_DI), .Mant_prenorm_DI(Mant_prenorm_DI),
    .Rm_SI(Rm_SI), .Out_Valid_SO(Out_Valid_SO), .Out_Ready_SI(Out_Ready_SI), .Result_DO(Result_DO),
    .OF_SO(OF_SO), .UF_SO(UF_SO), .NX_SO(NX_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct packed {
    logic [31:0] res;
    logic of;
    logic uf;
    logic nx;
  } exp_t;

  exp_t sb[$];
  exp_t in_exp;
  int n_assert = 0, n_fail = 0;
  bit pending = 0, hold_chk = 0, rnd_rdy = 0;
  logic [34:0] hold_val;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(bit s, logic [9:0] e, logic [47:0] m, logic [1:0] rm);
    exp_t r;
    int se, p, be, bee, k, ef;
    logic [127:0] mm, q, rem, half;
    bit nxr, tie, above, inc, tiny;
    if (m == 0) return '{res: {s, 31'd0}, of: 1'b0, uf: 1'b0, nx: 1'b0};
    se = int'($signed(e));
    for (p = 47; p > 0 && !m[p]; p--) ;
    be = se + p - 46;
    tiny = be < 1;
    bee = tiny ? 1 : be;
    k = bee - se + 23;
    mm = 128'(m);
    if (k <= 0) begin
      q = mm << (-k);
      rem = '0;
      half = 128'd1;
    end else if (k > 100) begin
      q = '0;
      rem = mm;
      half = '1;
    end else begin
      q = mm >> k;
      rem = mm - (q << k);
      half = 128'd1 << (k - 1);
    end
    nxr = rem != 0;
    tie = rem == half;
    above = rem > half;
    inc = rm == 2'd0 ? (above || (tie && q[0])) : rm == 2'd2 ? (s && nxr) : rm == 2'd3 ? (!s && nxr) : 1'b0;
    q = q + 128'(inc);
    if (q >= 128'h1000000) begin
      q = q >> 1;
      bee++;
    end
    ef = q < 128'h800000 ? 0 : bee;
`ifdef FPU_NORM_FLUSH_DENORM_EN
    if (tiny) return '{res: {s, 31'd0}, of: 1'b0, uf: 1'b1, nx: 1'b1};
`endif
    if (ef >= 255) begin
      r.res = {s, ((rm == 2'd0) || (rm == 2'd2 && s) || (rm == 2'd3 && !s)) ? 31'h7F800000 : 31'h7F7FFFFF};
      r.of = 1'b1;
      r.uf = 1'b0;
      r.nx = 1'b1;
    end else begin
      r.res = {s, 8'(ef), q[22:0]};
      r.of = 1'b0;
      r.uf = tiny && nxr;
      r.nx = nxr;
    end
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    if (rnd_rdy) Out_Ready_SI = $urandom_range(0, 3) != 0;
    #1;
    if (hold_chk) chk("hold_stable", {Result_DO, OF_SO, UF_SO, NX_SO}, hold_val);
    hold_chk = Out_Valid_SO && !Out_Ready_SI;
    hold_val = {Result_DO, OF_SO, UF_SO, NX_SO};
    if (Out_Valid_SO && Out_Ready_SI) begin
      if (sb.size() == 0) chk("spurious_out", 64'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("result", Result_DO, e.res);
        chk("flags_of_uf_nx", {OF_SO, UF_SO, NX_SO}, {e.of, e.uf, e.nx});
      end
    end
    if (In_Valid_SI && In_Ready_SO && pending) begin
      sb.push_back(in_exp);
      pending = 0;
    end
    @(posedge Clk_CI);
    @(negedge Clk_CI);
  endtask

  task automatic drive(bit s, logic [9:0] e, logic [47:0] m, logic [1:0] rm, exp_t ex);
    Sign_prenorm_DI = s;
    Exp_prenorm_DI = e;
    Mant_prenorm_DI = m;
    Rm_SI = rm;
    In_Valid_SI = 1'b1;
    in_exp = ex;
    pending = 1;
  endtask

  task automatic send(bit s, logic [9:0] e, logic [47:0] m, logic [1:0] rm, exp_t ex);
    drive(s, e, m, rm, ex);
    for (int n = 0; n < 200 && pending; n++) tick();
    chk("accept_timeout", 64'(pending), 0);
    pending = 0;
  endtask

  task automatic drain();
    In_Valid_SI = 1'b0;
    for (int n = 0; n < 200 && sb.size() > 0; n++) tick();
    chk("drain_left", 64'(sb.size()), 0);
    repeat (3) tick();
  endtask

  task automatic send_rnd();
    bit s;
    logic [9:0] e;
    logic [47:0] m;
    logic [1:0] rm;
    int sel;
    s = 1'($urandom);
    sel = $urandom_range(0, 4);
    e = sel == 0 ? 10'($urandom) : sel == 1 ? 10'($urandom_range(0, 50)) - 10'd30 :
        sel == 2 ? 10'($urandom_range(235, 265)) : 10'($urandom_range(60, 200));
    m = {16'($urandom), $urandom};
    m[47] = 1'b1;
    m = m >> ($urandom_range(0, 3) == 0 ? $urandom_range(0, 47) : $urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) m[23:0] = 24'd0;
    if ($urandom_range(0, 7) == 0) m[22:0] = 23'd0;
    rm = 2'($urandom);
    send(s, e, m, rm, model(s, e, m, rm));
  endtask

  localparam logic [47:0] ONE = 48'h400000000000;
  exp_t sub_exp, neg_rne, neg_rup;

  initial begin
    repeat (2) @(negedge Clk_CI);
    chk("rst_out_valid", 64'(Out_Valid_SO), 0);
    chk("rst_result", Result_DO, 0);
    chk("rst_flags", {OF_SO, UF_SO, NX_SO}, 0);
    chk("rst_in_ready", 64'(In_Ready_SO), 1);
    Rst_RI = 1'b0;
    @(negedge Clk_CI);

    send(0, 10'd127, ONE, 2'd0, '{32'h3F800000, 1'b0, 1'b0, 1'b0});
    In_Valid_SI = 1'b0;
    #1 chk("latency_c1", 64'(Out_Valid_SO), 0);
    tick();
    #1 chk("latency_c2", 64'(Out_Valid_SO), 1);
    drain();

`ifdef FPU_NORM_FLUSH_DENORM_EN
    sub_exp = '{32'h00000000, 1'b0, 1'b1, 1'b1};
    neg_rne = '{32'h00000000, 1'b0, 1'b1, 1'b1};
    neg_rup = '{32'h00000000, 1'b0, 1'b1, 1'b1};
`else
    sub_exp = '{32'h00001000, 1'b0, 1'b0, 1'b0};
    neg_rne = '{32'h00000000, 1'b0, 1'b1, 1'b1};
    neg_rup = '{32'h00000001, 1'b0, 1'b1, 1'b1};
`endif
    send(0, 10'd127, 48'h900000000000, 2'd0, '{32'h40100000, 1'b0, 1'b0, 1'b0});
    send(0, 10'd127, 48'h400000400000, 2'd0, '{32'h3F800000, 1'b0, 1'b0, 1'b1});
    send(0, 10'd127, 48'h400000400000, 2'd3, '{32'h3F800001, 1'b0, 1'b0, 1'b1});
    send(0, 10'd300, ONE, 2'd0, '{32'h7F800000, 1'b1, 1'b0, 1'b1});
    send(0, 10'd300, ONE, 2'd1, '{32'h7F7FFFFF, 1'b1, 1'b0, 1'b1});
    send(1, 10'd300, ONE, 2'd2, '{32'hFF800000, 1'b1, 1'b0, 1'b1});
    send(1, 10'd300, ONE, 2'd3, '{32'hFF7FFFFF, 1'b1, 1'b0, 1'b1});
    send(0, 10'h3F6, ONE, 2'd0, sub_exp);
    send(1, 10'd5, 48'd0, 2'd3, '{32'h80000000, 1'b0, 1'b0, 1'b0});
    send(0, 10'h200, 48'd1, 2'd0, neg_rne);
    send(0, 10'h200, 48'd1, 2'd3, neg_rup);
    drain();

    Out_Ready_SI = 1'b0;
    send(0, 10'd127, ONE, 2'd0, model(0, 10'd127, ONE, 2'd0));
    send(1, 10'd128, 48'h900000000000, 2'd0, model(1, 10'd128, 48'h900000000000, 2'd0));
    drive(0, 10'd126, 48'h600000000000, 2'd1, model(0, 10'd126, 48'h600000000000, 2'd1));
    #1 chk("stall_in_ready_low", 64'(In_Ready_SO), 0);
    repeat (4) tick();
    chk("stall_out_valid", 64'(Out_Valid_SO), 1);
    Out_Ready_SI = 1'b1;
    for (int n = 0; n < 20 && pending; n++) tick();
    chk("stall_third_accept", 64'(pending), 0);
    pending = 0;
    drain();

    send(0, 10'd127, ONE, 2'd0, model(0, 10'd127, ONE, 2'd0));
    send(0, 10'd128, ONE, 2'd0, model(0, 10'd128, ONE, 2'd0));
    In_Valid_SI = 1'b0;
    #2 Rst_RI = 1'b1;
    #1 chk("midrst_out_valid", 64'(Out_Valid_SO), 0);
    chk("midrst_result", Result_DO, 0);
    chk("midrst_in_ready", 64'(In_Ready_SO), 1);
    sb.delete();
    hold_chk = 0;
    pending = 0;
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    repeat (2) tick();
    chk("postrst_idle", 64'(Out_Valid_SO), 0);

    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send_rnd();
      if ($urandom_range(0, 4) == 0) begin
        In_Valid_SI = 1'b0;
        tick();
      end
    end
    rnd_rdy = 0;
    Out_Ready_SI = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
